// File: rtl/arilla_bus_pkg.sv
// Shared types and helpers for the arilla bus arbiter.
package arilla_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned arilla_word_addr_width(input int unsigned data_width,
                                                         input int unsigned address_width);
    return address_width - $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/arilla_rr_picker.sv
// Rotate-priority encoder: picks the first active channel at or above pointer, wrapping.
module arilla_rr_picker #(
  parameter int unsigned Channels = 2,
  parameter int unsigned PtrW     = 1
) (
  input  logic [Channels-1:0] active,
  input  logic [PtrW-1:0]     pointer,
  output logic [Channels-1:0] winner,
  output logic                any
);

  logic found;

  // Upper half [pointer, Channels) first, then the wrapped lower half.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    any    = |active;
    for (int unsigned i = 0; i < Channels; i++) begin
      if (!found && active[i] && (i >= 32'(pointer))) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < Channels; i++) begin
      if (!found && active[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin N-initiator arbiter onto one arilla bus target; grant held per transaction.
// Optional bus timeout enabled by defining ARILLA_BUS_ARBITER_TIMEOUT_EN.
module arilla_bus_arbiter
  import arilla_bus_pkg::*;
#(
  parameter  int unsigned Channels           = 2,
  parameter  int unsigned DataWidth          = 32,
  parameter  int unsigned AddressWidth       = 32,
  parameter  int unsigned TimeoutCycles      = 256,
  localparam int unsigned ByteEnables        = DataWidth / 8,
  localparam int unsigned ActualAddressWidth = arilla_word_addr_width(DataWidth, AddressWidth)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [Channels-1:0][ActualAddressWidth-1:0] req_address,
  input  logic [Channels-1:0][DataWidth-1:0]          req_wdata,
  input  logic [Channels-1:0][ByteEnables-1:0]        req_byte_enable,
  input  logic [Channels-1:0]                         req_read,
  input  logic [Channels-1:0]                         req_write,
  output logic [Channels-1:0][DataWidth-1:0]          req_rdata,
  output logic [Channels-1:0]                         req_available,
  output logic [Channels-1:0]                         req_intercept,
  output logic [ActualAddressWidth-1:0]               bus_address,
  output logic [DataWidth-1:0]                        bus_wdata,
  output logic [ByteEnables-1:0]                      bus_byte_enable,
  output logic                                        bus_read,
  output logic                                        bus_write,
  input  logic [DataWidth-1:0]                        bus_rdata,
  input  logic                                        bus_available,
  input  logic                                        bus_intercept,
  output logic [Channels-1:0]                         grant,
  output logic                                        timeout
);

  localparam int unsigned PtrW = (Channels > 1) ? $clog2(Channels) : 1;

  arb_state_e                    state_q;
  logic [PtrW-1:0]               ptr_q;
  logic [Channels-1:0]           grant_q;
  logic [ActualAddressWidth-1:0] bus_address_q;
  logic [DataWidth-1:0]          bus_wdata_q;
  logic [ByteEnables-1:0]        bus_be_q;
  logic                          bus_read_q;
  logic                          bus_write_q;

  logic [Channels-1:0] active;
  logic [Channels-1:0] winner;
  logic                any;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW-1:0]     grant_idx;
  logic [PtrW-1:0]     ptr_next;
  logic                expire;
  logic                done;

  always_comb active = req_read | req_write;

  arilla_rr_picker #(
    .Channels(Channels),
    .PtrW    (PtrW)
  ) u_picker (
    .active (active),
    .pointer(ptr_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    win_idx   = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < Channels; i++) begin
      if (winner[i])  win_idx   = PtrW'(i);
      if (grant_q[i]) grant_idx = PtrW'(i);
    end
    ptr_next = PtrW'((32'(grant_idx) + 32'd1) % Channels);
  end

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  // A target answer in the expiry cycle takes precedence over the timeout.
  always_comb expire = (state_q == BUSY) && !bus_available && (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == BUSY) && !done) cnt_q <= cnt_q + 1'b1;
      else                            cnt_q <= '0;
      if (expire) timeout_q <= 1'b1;
    end
  end

  always_comb timeout = timeout_q;
`else
  always_comb expire  = 1'b0;
  always_comb timeout = 1'b0;
`endif

  always_comb done = (state_q == BUSY) && (bus_available || expire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
      bus_be_q      <= '0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            bus_address_q <= req_address[win_idx];
            bus_wdata_q   <= req_wdata[win_idx];
            bus_be_q      <= req_byte_enable[win_idx];
            // A simultaneous read+write is forwarded as a write.
            bus_write_q   <= req_write[win_idx];
            bus_read_q    <= req_read[win_idx] & ~req_write[win_idx];
            grant_q       <= winner;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            ptr_q       <= ptr_next;
            grant_q     <= '0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_available = '0;
    req_intercept = '0;
    req_rdata     = '0;
    if (done) begin
      req_available = grant_q;
      if (bus_available) begin
        req_intercept = grant_q & {Channels{bus_intercept}};
        for (int unsigned i = 0; i < Channels; i++) begin
          if (grant_q[i]) req_rdata[i] = bus_rdata;
        end
      end
    end
  end

  always_comb begin
    grant           = grant_q;
    bus_address     = bus_address_q;
    bus_wdata       = bus_wdata_q;
    bus_byte_enable = bus_be_q;
    bus_read        = bus_read_q;
    bus_write       = bus_write_q;
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Self-checking bench for arilla_bus_arbiter (3 channels, TimeoutCycles=4).
`timescale 1ns/1ps
module tb_arilla_bus_arbiter;

  localparam int C   = 3;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BE  = 4;
  localparam int AAW = 30;
  localparam int TO  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [C-1:0][AAW-1:0] req_address;
  logic [C-1:0][DW-1:0]  req_wdata;
  logic [C-1:0][BE-1:0]  req_byte_enable;
  logic [C-1:0]          req_read, req_write;
  logic [C-1:0][DW-1:0]  req_rdata;
  logic [C-1:0]          req_available, req_intercept;
  logic [AAW-1:0]        bus_address;
  logic [DW-1:0]         bus_wdata;
  logic [BE-1:0]         bus_byte_enable;
  logic                  bus_read, bus_write;
  logic [DW-1:0]         bus_rdata;
  logic                  bus_available, bus_intercept;
  logic [C-1:0]          grant;
  logic                  timeout;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  arilla_bus_arbiter #(
    .Channels     (C),
    .DataWidth    (DW),
    .AddressWidth (AW),
    .TimeoutCycles(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_address    (req_address),
    .req_wdata      (req_wdata),
    .req_byte_enable(req_byte_enable),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_rdata      (req_rdata),
    .req_available  (req_available),
    .req_intercept  (req_intercept),
    .bus_address    (bus_address),
    .bus_wdata      (bus_wdata),
    .bus_byte_enable(bus_byte_enable),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_rdata      (bus_rdata),
    .bus_available  (bus_available),
    .bus_intercept  (bus_intercept),
    .grant          (grant),
    .timeout        (timeout)
  );

  // Round-robin rule: first requesting channel at index >= p, wrapping; -1 if none.
  function automatic int pick(input logic [C-1:0] act, input int p);
    for (int k = 0; k < C; k++) begin
      int idx;
      idx = (p + k) % C;
      if (act[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [C-1:0] onehot(input int w);
    logic [C-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_address     = '0;
    req_wdata       = '0;
    req_byte_enable = '0;
    req_read        = '0;
    req_write       = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus_available = 1'b0;
    bus_intercept = 1'b0;
    bus_rdata     = '0;
    clear_reqs();
    tick();
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_available = 1'b0;
    bus_intercept = 1'b0;
    bus_rdata     = '0;
    clear_reqs();
    tick();
    tick();
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
    checks++; if ({bus_read, bus_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {bus_read, bus_write}); end
    checks++; if (bus_address !== '0 || bus_wdata !== '0 || bus_byte_enable !== '0) begin errors++; $display("FAIL reset_bus: got %h/%h/%h expected 0", bus_address, bus_wdata, bus_byte_enable); end
    checks++; if (req_available !== '0 || req_intercept !== '0 || req_rdata !== '0) begin errors++; $display("FAIL reset_resp: got %b/%b expected 0", req_available, req_intercept); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    rst   = 1'b0;
    m_ptr = 0;
    tick();
    checks++; if (grant !== '0) begin errors++; $display("FAIL idle_no_req_grant: got %b expected 000", grant); end
  endtask

  task automatic test_single_read();
    req_read[0]    = 1'b1;
    req_address[0] = 30'h10;
    tick();
    checks++; if ({bus_read, bus_write} !== 2'b10) begin errors++; $display("FAIL single_strobes: got %b expected 10", {bus_read, bus_write}); end
    checks++; if (bus_address !== 30'h10) begin errors++; $display("FAIL single_addr: got %h expected 10", bus_address); end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", grant); end
    bus_available = 1'b1;
    bus_rdata     = 32'hDEADBEEF;
    #1;
    checks++; if (req_available !== 3'b001) begin errors++; $display("FAIL single_avail: got %b expected 001", req_available); end
    checks++; if (req_rdata !== {32'h0, 32'h0, 32'hDEADBEEF}) begin errors++; $display("FAIL single_rdata: got %h expected DEADBEEF on ch0 only", req_rdata); end
    tick();
    bus_available = 1'b0;
    req_read[0]   = 1'b0;
    checks++; if (grant !== '0 || bus_read !== 1'b0) begin errors++; $display("FAIL single_idle: got grant %b read %b expected 000 0", grant, bus_read); end
    m_ptr = 1;
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < C; i++) begin
      req_read[i]    = 1'b1;
      req_address[i] = AAW'(32'h100 + i);
    end
    for (int n = 0; n < 7; n++) begin
      int w;
      w = pick(req_read | req_write, m_ptr);
      tick();
      checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", n, grant, onehot(w)); end
      checks++; if (bus_address !== AAW'(32'h100 + w)) begin errors++; $display("FAIL contention_addr%0d: got %h expected %h", n, bus_address, 32'h100 + w); end
      bus_available = 1'b1;
      bus_rdata     = 32'(n);
      #1;
      checks++; if (req_available !== onehot(w)) begin errors++; $display("FAIL contention_avail%0d: got %b expected %b", n, req_available, onehot(w)); end
      tick();
      bus_available = 1'b0;
      checks++; if (grant !== '0) begin errors++; $display("FAIL contention_gap%0d: got %b expected 000", n, grant); end
      m_ptr = (w + 1) % C;
    end
    clear_reqs();
  endtask

  task automatic test_write_intercept();
    logic [AAW-1:0] a;
    logic [DW-1:0]  d;
    int w;
    a = AAW'($urandom);
    d = $urandom;
    req_write[1]       = 1'b1;
    req_address[1]     = a;
    req_wdata[1]       = d;
    req_byte_enable[1] = 4'b0101;
    w = pick(req_read | req_write, m_ptr);
    tick();
    checks++; if (grant !== 3'b010 || w != 1) begin errors++; $display("FAIL wr_grant: got %b expected 010", grant); end
    checks++; if ({bus_read, bus_write} !== 2'b01) begin errors++; $display("FAIL wr_strobes: got %b expected 01", {bus_read, bus_write}); end
    for (int s = 0; s < 2; s++) begin
      req_address[1]     = ~req_address[1];
      req_wdata[1]       = ~req_wdata[1];
      req_byte_enable[1] = ~req_byte_enable[1];
      req_write[1]       = ~req_write[1];
      req_read[1]        = ~req_read[1];
      tick();
      checks++; if (bus_address !== a || bus_wdata !== d || bus_byte_enable !== 4'b0101 || bus_write !== 1'b1) begin
        errors++; $display("FAIL wr_hold%0d: got %h/%h/%b/%b expected %h/%h/0101/1", s, bus_address, bus_wdata, bus_byte_enable, bus_write, a, d);
      end
    end
    bus_available = 1'b1;
    bus_intercept = 1'b1;
    bus_rdata     = 32'h0BADF00D;
    #1;
    checks++; if (req_intercept !== 3'b010) begin errors++; $display("FAIL wr_intercept: got %b expected 010", req_intercept); end
    checks++; if (req_available !== 3'b010) begin errors++; $display("FAIL wr_avail: got %b expected 010", req_available); end
    tick();
    bus_available = 1'b0;
    bus_intercept = 1'b0;
    clear_reqs();
    m_ptr = 2;
  endtask

  task automatic test_reset_busy();
    req_read[2] = 1'b1;
    tick();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rstbusy_grant: got %b expected 100", grant); end
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (grant !== '0 || bus_read !== 1'b0 || bus_write !== 1'b0 || bus_address !== '0) begin
      errors++; $display("FAIL rstbusy_async: got grant %b rd %b wr %b addr %h expected all 0", grant, bus_read, bus_write, bus_address);
    end
    checks++; if (req_available !== '0) begin errors++; $display("FAIL rstbusy_avail: got %b expected 000", req_available); end
    #1;
    rst   = 1'b0;
    m_ptr = 0;
    req_read = '1;
    tick();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rstbusy_restart: got %b expected 001", grant); end
    bus_available = 1'b1;
    #1;
    checks++; if (req_available !== 3'b001) begin errors++; $display("FAIL rstbusy_done: got %b expected 001", req_available); end
    tick();
    bus_available = 1'b0;
    clear_reqs();
    m_ptr = 1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      int w;
      int stall;
      logic [AAW-1:0] sa;
      logic [DW-1:0]  sd;
      logic [BE-1:0]  sb;
      logic           srd, swr, icpt;
      logic [C-1:0][DW-1:0] exp_rd;
      for (int i = 0; i < C; i++) begin
        logic [1:0] op;
        op = 2'($urandom_range(0, 3));
        req_read[i]        = op[0];
        req_write[i]       = op[1];
        req_address[i]     = AAW'($urandom);
        req_wdata[i]       = $urandom;
        req_byte_enable[i] = BE'($urandom);
      end
      w = pick(req_read | req_write, m_ptr);
      if (w >= 0) begin
        sa = req_address[w]; sd = req_wdata[w]; sb = req_byte_enable[w];
        srd = req_read[w]; swr = req_write[w];
      end
      tick();
      if (w < 0) begin
        checks++; if (grant !== '0 || bus_read !== 1'b0 || bus_write !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d: got grant %b expected 000", r, grant); end
        continue;
      end
      checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL rnd_grant%0d: got %b expected %b", r, grant, onehot(w)); end
      checks++; if (bus_address !== sa || bus_wdata !== sd || bus_byte_enable !== sb) begin
        errors++; $display("FAIL rnd_capture%0d: got %h/%h/%h expected %h/%h/%h", r, bus_address, bus_wdata, bus_byte_enable, sa, sd, sb);
      end
      checks++; if (bus_read !== (srd & ~swr) || bus_write !== swr) begin
        errors++; $display("FAIL rnd_op%0d: got rd %b wr %b expected rd %b wr %b", r, bus_read, bus_write, srd & ~swr, swr);
      end
      stall = $urandom_range(0, TO - 1);
      for (int s = 0; s < stall; s++) begin
        for (int i = 0; i < C; i++) begin
          req_read[i]    = 1'($urandom);
          req_write[i]   = 1'($urandom);
          req_address[i] = AAW'($urandom);
          req_wdata[i]   = $urandom;
        end
        #1;
        checks++; if (req_available !== '0) begin errors++; $display("FAIL rnd_stall_avail%0d: got %b expected 000", r, req_available); end
        tick();
        checks++; if (grant !== onehot(w) || bus_address !== sa || bus_wdata !== sd) begin
          errors++; $display("FAIL rnd_stall_hold%0d: got %b/%h/%h expected %b/%h/%h", r, grant, bus_address, bus_wdata, onehot(w), sa, sd);
        end
      end
      icpt          = 1'($urandom);
      bus_rdata     = $urandom;
      bus_intercept = icpt;
      bus_available = 1'b1;
      exp_rd        = '0;
      exp_rd[w]     = bus_rdata;
      #1;
      checks++; if (req_available !== onehot(w)) begin errors++; $display("FAIL rnd_avail%0d: got %b expected %b", r, req_available, onehot(w)); end
      checks++; if (req_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata%0d: got %h expected %h", r, req_rdata, exp_rd); end
      checks++; if (req_intercept !== (icpt ? onehot(w) : 3'b000)) begin errors++; $display("FAIL rnd_icpt%0d: got %b expected %b", r, req_intercept, icpt ? onehot(w) : 3'b000); end
      tick();
      bus_available = 1'b0;
      bus_intercept = 1'b0;
      checks++; if (grant !== '0 || bus_read !== 1'b0 || bus_write !== 1'b0) begin
        errors++; $display("FAIL rnd_release%0d: got grant %b rd %b wr %b expected 000 0 0", r, grant, bus_read, bus_write);
      end
      m_ptr = (w + 1) % C;
      clear_reqs();
    end
  endtask

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    req_read[0]   = 1'b1;
    bus_rdata     = 32'hA5A5A5A5;
    bus_intercept = 1'b1;
    tick();
    for (int c = 1; c < TO; c++) begin
      #1;
      checks++; if (req_available !== '0) begin errors++; $display("FAIL to_early%0d: got %b expected 000", c, req_available); end
      tick();
    end
    #1;
    checks++; if (req_available !== 3'b001) begin errors++; $display("FAIL to_avail: got %b expected 001", req_available); end
    checks++; if (req_rdata !== '0 || req_intercept !== '0) begin errors++; $display("FAIL to_zero: got %h/%b expected 0/000", req_rdata, req_intercept); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pre: got %b expected 0", timeout); end
    tick();
    clear_reqs();
    bus_intercept = 1'b0;
    m_ptr = 1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", timeout); end
    checks++; if (grant !== '0 || bus_read !== 1'b0) begin errors++; $display("FAIL to_release: got %b/%b expected 000/0", grant, bus_read); end
    req_write[1] = 1'b1;
    tick();
    bus_available = 1'b1;
    tick();
    bus_available = 1'b0;
    clear_reqs();
    m_ptr = 2;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout); end
    apply_reset();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_reset: got %b expected 0", timeout); end
  endtask

  task automatic test_timeout_race();
    apply_reset();
    req_read[0] = 1'b1;
    tick();
    for (int c = 1; c < TO; c++) tick();
    bus_available = 1'b1;
    bus_rdata     = 32'h12345678;
    #1;
    checks++; if (req_available !== 3'b001 || req_rdata[0] !== 32'h12345678) begin
      errors++; $display("FAIL race_done: got %b/%h expected 001/12345678", req_available, req_rdata[0]);
    end
    tick();
    bus_available = 1'b0;
    clear_reqs();
    m_ptr = 1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL race_timeout: got %b expected 0", timeout); end
  endtask
`else
  task automatic test_no_timeout();
    int w;
    req_read = 3'b111;
    w = pick(req_read, m_ptr);
    tick();
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++; if (req_available !== '0 || timeout !== 1'b0) begin errors++; $display("FAIL wait%0d: got %b/%b expected 000/0", c, req_available, timeout); end
      tick();
    end
    checks++; if (grant !== onehot(w)) begin errors++; $display("FAIL wait_grant: got %b expected %b", grant, onehot(w)); end
    bus_available = 1'b1;
    tick();
    bus_available = 1'b0;
    clear_reqs();
    m_ptr = (w + 1) % C;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_intercept();
    test_reset_busy();
    test_random();
`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
